// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared defaults and helpers for the parametrised sync FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

    // Default configuration of the FIFO family.
    localparam int c_DEFAULT_WIDTH    = 32;
    localparam int c_DEFAULT_DEPTH    = 8;
    localparam int c_DEFAULT_AE_LEVEL = 1;

    // Pointer/count width: address bits plus one wrap bit, so a count of
    // exactly DEPTH is representable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_mem
//  Description : DEPTH x WIDTH storage array. One synchronous write port,
//                one asynchronous (combinational) read port. Not reset.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
    output logic [WIDTH-1:0]           rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the incoming word into the addressed entry on an accepted push.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port is purely combinational so the top can either register it
    // or present it directly (fall-through).
    assign rd_data_o = mem_q[rd_addr_i];

endmodule : fifo_mem
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sync_param
//  Description : Parametrised single-clock FIFO with occupancy count,
//                almost-full/almost-empty thresholds, sticky overflow and
//                underflow flags and a synchronous flush.
//                Build option FIFO_FWFT_EN: first-word-fall-through output
//                (head word shown while not empty). Without it the output
//                is a register loaded on each accepted pop.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = c_DEFAULT_WIDTH,
    parameter int DEPTH    = c_DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = c_DEFAULT_AE_LEVEL
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              dataIn,
    output logic [WIDTH-1:0]              fifo_out,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [ptr_width(DEPTH)-1:0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] c_PTR_ONE = PW'(1);
    localparam logic [PW-1:0] c_FULL_COUNT = PW'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q,  count_d;
    logic          overflow_q,  overflow_d;
    logic          underflow_q, underflow_d;

    logic          w_full;
    logic          w_empty;
    logic          w_pop_ok;
    logic          w_push_ok;
    logic          w_mem_wr_en;
    logic [WIDTH-1:0] w_rd_data;

    // Flags come only from the registered count, never from push/pop.
    assign w_full  = (count_q == c_FULL_COUNT);
    assign w_empty = (count_q == '0);

    // A pop needs data; a push may use the slot freed by a same-cycle pop,
    // which is what allows full throughput while full.
    assign w_pop_ok  = pop & ~w_empty;
    assign w_push_ok = push & (~w_full | w_pop_ok);

    // A flush suppresses the write so stale data is not half-committed.
    assign w_mem_wr_en = w_push_ok & ~clear;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_mem (
        .clk       (clk),
        .wr_en_i   (w_mem_wr_en),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (dataIn),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (w_rd_data)
    );

    // Next-state for pointers, occupancy and sticky error flags; flush wins.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            // DEPTH is a power of two, so plain increment wraps the address
            // bits to zero and toggles the wrap bit.
            if (w_push_ok) begin
                wr_ptr_d = wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                rd_ptr_d = rd_ptr_q + c_PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   count_d = count_q + c_PTR_ONE;
                2'b01:   count_d = count_q - c_PTR_ONE;
                default: count_d = count_q;
            endcase
            overflow_d  = overflow_q  | (push & ~w_push_ok);
            underflow_d = underflow_q | (pop  & ~w_pop_ok);
        end
    end

    // Control state register; asynchronous reset empties the FIFO at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
`ifdef FIFO_FWFT_EN
    // Head word is visible directly; forced to zero when nothing is stored
    // so uninitialised memory never leaks out.
    assign fifo_out = w_empty ? '0 : w_rd_data;
`else
    logic [WIDTH-1:0] fifo_out_q, fifo_out_d;

    // Load the head word on an accepted pop, otherwise hold; flush zeroes it.
    always_comb begin
        fifo_out_d = fifo_out_q;
        if (clear) begin
            fifo_out_d = '0;
        end else if (w_pop_ok) begin
            fifo_out_d = w_rd_data;
        end
    end

    // Output data register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_out_q <= '0;
        end else begin
            fifo_out_q <= fifo_out_d;
        end
    end

    assign fifo_out = fifo_out_q;
`endif

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    assign fifo_full    = w_full;
    assign fifo_empty   = w_empty;
    assign almost_full  = (int'(count_q) >= AF_LEVEL);
    assign almost_empty = (int'(count_q) <= AE_LEVEL);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule : fifo_sync_param
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_sync_param
//  Description : Self-checking bench for fifo_sync_param (WIDTH=32, DEPTH=4,
//                AF_LEVEL=3, AE_LEVEL=1). Works in both FIFO_FWFT_EN builds.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_sync_param;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk    = 1'b0;
    logic             reset  = 1'b0;
    logic             clear  = 1'b0;
    logic             push   = 1'b0;
    logic             pop    = 1'b0;
    logic [WIDTH-1:0] dataIn = '0;
    logic [WIDTH-1:0] fifo_out;
    logic             fifo_full;
    logic             fifo_empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue of stored words plus sticky flags and the
    // last word delivered by a pop (registered-output build).
    logic [31:0] sb[$];
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;
    logic [31:0] m_out = '0;

    fifo_sync_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .push         (push),
        .pop          (pop),
        .dataIn       (dataIn),
        .fifo_out     (fifo_out),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic check_state(input string where);
        int n;
        logic [31:0] exp_out;
        n = sb.size();
        check({where, " count"},        32'(count),        32'(n));
        check({where, " fifo_empty"},   32'(fifo_empty),   32'(n == 0));
        check({where, " fifo_full"},    32'(fifo_full),    32'(n == DEPTH));
        check({where, " almost_full"},  32'(almost_full),  32'(n >= AF));
        check({where, " almost_empty"}, 32'(almost_empty), 32'(n <= AE));
        check({where, " overflow"},     32'(overflow),     32'(m_ovf));
        check({where, " underflow"},    32'(underflow),    32'(m_unf));
`ifdef FIFO_FWFT_EN
        if (n == 0) exp_out = '0;
        else        exp_out = sb[0];
`else
        exp_out = m_out;
`endif
        check({where, " fifo_out"}, fifo_out, exp_out);
    endtask

    // One clock with the given request; model decides acceptance from its
    // own occupancy before the edge and is updated after it.
    task automatic step(input bit p, input bit q, input logic [31:0] d, input string where);
        bit pop_ok;
        bit push_ok;
        pop_ok  = q && (sb.size() != 0);
        push_ok = p && ((sb.size() != DEPTH) || pop_ok);
        push   = p;
        pop    = q;
        dataIn = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        if (pop_ok)   m_out = sb.pop_front();
        if (push_ok)  sb.push_back(d);
        if (p && !push_ok) m_ovf = 1'b1;
        if (q && !pop_ok)  m_unf = 1'b1;
        check_state(where);
    endtask

    task automatic model_reset();
        sb.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_out = '0;
    endtask

    initial begin
        // Power-on reset
        #12;
        check_state("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Empty: lone pop, then push+pop together, then read the 7 back
        step(1'b0, 1'b1, 32'd0, "pop_empty");
        step(1'b1, 1'b1, 32'd7, "push_pop_empty");
        step(1'b0, 1'b1, 32'd0, "pop_7");
        check("pop_7 value", m_out, 32'd7);

        // Build count=2 then reset asynchronously between edges
        step(1'b1, 1'b0, 32'd10, "fill_a");
        step(1'b1, 1'b0, 32'd11, "fill_b");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_state("async_reset");
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_state("after_reset");

        // Fill to full, drain in order
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 32'(i), "fill");
        for (int i = 0; i < 4; i++)  step(1'b0, 1'b1, 32'd0, "drain");

        // Refill, overflow, then push+pop while full
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 32'(i), "refill");
        step(1'b1, 1'b0, 32'd5, "push_full");
        step(1'b1, 1'b1, 32'd6, "push_pop_full");

        // Down to 3 entries and stream for 10 cycles (two pointer wraps)
        step(1'b0, 1'b1, 32'd0, "to_three");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 32'(32'h100 + i), "stream");

        // Flush with a simultaneous push: push must be ignored
        push   = 1'b1;
        dataIn = 32'hDEAD;
        clear  = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        push  = 1'b0;
        model_reset();
        check_state("clear");

        // FIFO usable after flush
        step(1'b1, 1'b0, 32'hABCD, "post_clear_push");
        step(1'b0, 1'b1, 32'd0, "post_clear_pop");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fifo_sync_param
`default_nettype wire

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous FIFO, successor to the fixed-size 32-bit FIFO. Adds configurable width/depth, occupancy count, programmable almost-full/almost-empty thresholds, simultaneous push/pop at full and empty, sticky overflow/underflow error flags, a synchronous flush, and optional first-word-fall-through output. Sits between any single-clock producer/consumer pair in the datapath.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-1, almost_full asserted when count ≥ AF_LEVEL
- AE_LEVEL, 1, almost_empty asserted when count ≤ AE_LEVEL
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush, active-high
- push  in  1  write request
- pop  in  1  read request
- dataIn  in  WIDTH  write data, sampled on accepted push
- fifo_out  out  WIDTH  read data
- fifo_full  out  1  count == DEPTH
- fifo_empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: push rejected while full
- underflow  out  1  sticky: pop rejected while empty

## Operation
- Pointers wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits; low bits address memory, MSB is wrap bit; wrap from DEPTH-1 to 0 toggles MSB.
- pop_ok = pop & !fifo_empty; push_ok = push & (!fifo_full | pop_ok).
- push_ok writes dataIn at wr_ptr, increments wr_ptr. pop_ok increments rd_ptr.
- count: +1 on push_ok only, −1 on pop_ok only, unchanged on both or neither. Never exceeds DEPTH, never below 0.
- Full + push + pop: both accepted, count stays DEPTH, no overflow.
- Empty + push + pop: pop rejected (underflow set), push accepted, count → 1.
- overflow set on push & !push_ok; underflow set on pop & !pop_ok. Cleared only by reset or clear.
- clear has priority over push/pop: pointers, count, overflow, underflow → 0; fifo_out → 0; memory contents not cleared.
- All flags are decoded from registered count/pointers; no combinational path from push/pop to any flag.
- Reset values: count 0, fifo_empty 1, fifo_full 0, almost_empty 1, almost_full 0 (AF_LEVEL>0), overflow 0, underflow 0, fifo_out 0. Memory not reset.
- Reset asserted mid-operation discards all contents immediately (asynchronous), same values as above.

## Timing
- Flags and count update in the cycle after the accepting edge.
- Standard mode: fifo_out is a register loaded with the head word on pop_ok edge; data valid 1 cycle after pop; held otherwise.
- FWFT mode: head word presented on fifo_out while !fifo_empty, 0 while empty; first word visible the cycle after its push edge; pop_ok advances to the next word at that edge.
- Push-to-not-empty latency: 1 cycle. Full throughput: one push and one pop per cycle.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through; fifo_out driven from memory read port at rd_ptr, gated to 0 when empty.
- FIFO_FWFT_EN undefined: registered output as in Timing/standard mode; 1-cycle read latency.
- Flag, count and error behaviour identical in both builds.

## Structure
- Package fifo_pkg: default WIDTH/DEPTH/threshold constants, pointer-width helper function (clog2+1).
- Sub-module fifo_mem: DEPTH×WIDTH storage, one synchronous write port, one asynchronous read port; no reset.
- Top holds pointers, count, flags, error logic and output register/mux.

## Test plan
WIDTH=32, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1, both FIFO_FWFT_EN builds.
- Reset low mid-stream with count=2 -> immediately count=0, fifo_empty=1, fifo_out=0, overflow=underflow=0.
- Push 1,2,3,4 -> count 4, fifo_full=1, almost_full from count 3; pop ×4 returns 1,2,3,4 in order (standard: one cycle after each pop), fifo_empty=1.
- Full, push 5 alone -> rejected, overflow=1 sticky, count 4; then push 6 + pop together -> pops 1, 6 stored, overflow still 1.
- Empty, pop alone -> underflow=1, count 0; push 7 + pop same cycle -> count 1, head 7.
- Fill to 3, push/pop 10 cycles continuously -> pointer wrap twice, count stays 3, data order preserved.
- Count 3 with overflow=1, assert clear with push=1 -> count 0, fifo_empty=1, overflow=0, push ignored.
